// File: rtl/tpx3_shutter_seq.sv
// tpx3_shutter_seq
//
// Frame sequencer for the Timepix3 readout chain. A single accepted START
// runs a T0 / delay / (open, gap)* schedule on SHUTTER and T0_SYNC for
// REPEAT frames, or indefinitely when REPEAT is 0, until STOP or reset.
//
// Optional feature macro: TPX3_SHUTTER_SEQ_TPULSE_EN
//   When defined, test-pulse ports TP_PERIOD, TP_NUM and EXT_TPULSE are added
//   and a pulse train is generated inside every OPEN phase.
//
// Ports
//   CLK         sequencer clock (rising edge)
//   RST_N       asynchronous active-low reset
//   START       start request, sampled only while idle
//   STOP        abort request, honoured in any busy state
//   T0_EN       emit a T0_SYNC pulse at sequence start
//   DELAY       cycles from T0 to the first shutter open
//   LENGTH      shutter-open cycles per frame (0 behaves as 1)
//   GAP         shutter-closed cycles between frames (0 behaves as 1)
//   REPEAT      frame count, 0 = continuous
//   TP_PERIOD   (feature) cycles per test pulse
//   TP_NUM      (feature) test pulses per frame
//   EXT_TPULSE  (feature) test-pulse line
//   SHUTTER     shutter line, active high
//   T0_SYNC     one-cycle timestamp reset pulse
//   BUSY        high whenever not idle
//   DONE        one-cycle pulse at sequence end (normal or abort)
//   FRAME_CNT   frames completed since the last accepted START

module tpx3_shutter_seq #(
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned FRAME_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   START,
  input  logic                   STOP,
  input  logic                   T0_EN,
  input  logic [CNT_WIDTH-1:0]   DELAY,
  input  logic [CNT_WIDTH-1:0]   LENGTH,
  input  logic [CNT_WIDTH-1:0]   GAP,
  input  logic [FRAME_WIDTH-1:0] REPEAT,
`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
  input  logic [15:0]            TP_PERIOD,
  input  logic [15:0]            TP_NUM,
  output logic                   EXT_TPULSE,
`endif
  output logic                   SHUTTER,
  output logic                   T0_SYNC,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [FRAME_WIDTH-1:0] FRAME_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_WAIT,
    S_OPEN,
    S_GAP
  } state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic [FRAME_WIDTH-1:0] frame_n;
  logic [FRAME_WIDTH-1:0] frame_inc;
  logic                   done_n;
  logic                   accept;

  // Configuration captured when START is accepted
  logic [CNT_WIDTH-1:0]   dly_q, len_q, gap_q;
  logic [FRAME_WIDTH-1:0] rep_q;

  // Down-counter reload value: a zero length still lasts one cycle
  function automatic logic [CNT_WIDTH-1:0] ld(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_WIDTH'(1);
  endfunction

  assign frame_inc = FRAME_CNT + FRAME_WIDTH'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frame_n = FRAME_CNT;
    done_n  = 1'b0;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (START && !STOP) begin
          accept  = 1'b1;
          state_n = S_T0;
          frame_n = '0;
        end
      end
      S_T0: begin
        if (STOP) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (dly_q != '0) begin
          state_n = S_WAIT;
          cnt_n   = dly_q - CNT_WIDTH'(1);
        end else begin
          state_n = S_OPEN;
          cnt_n   = ld(len_q);
        end
      end
      S_WAIT: begin
        if (STOP) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_OPEN;
          cnt_n   = ld(len_q);
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      S_OPEN: begin
        // An aborted frame is not counted, so STOP is checked before the
        // end-of-frame increment.
        if (STOP) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (cnt == '0) begin
          frame_n = frame_inc;
          if (rep_q != '0 && frame_inc == rep_q) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_GAP;
            cnt_n   = ld(gap_q);
          end
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      S_GAP: begin
        if (STOP) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_OPEN;
          cnt_n   = ld(len_q);
        end else begin
          cnt_n = cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they change on the
  // same edge as the state they describe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dly_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      SHUTTER   <= 1'b0;
      T0_SYNC   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      SHUTTER   <= (state_n == S_OPEN);
      T0_SYNC   <= accept & T0_EN;
      BUSY      <= (state_n != S_IDLE);
      DONE      <= done_n;
      FRAME_CNT <= frame_n;
      if (accept) begin
        dly_q <= DELAY;
        len_q <= LENGTH;
        gap_q <= GAP;
        rep_q <= REPEAT;
      end
    end
  end

`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
  // Test-pulse train. tp_arm marks the first OPEN cycle, which is idle;
  // tp_ph is the phase within the current pulse period and tp_left the
  // pulses not yet finished in this frame.
  logic [15:0] tp_per_q, tp_num_q;
  logic [15:0] tp_ph, tp_left;
  logic        tp_arm;
  logic        tp_wrap;
  logic [15:0] tp_ph_n, tp_left_n;
  logic        ext_n;

  always_comb begin
    tp_wrap   = (tp_ph == tp_per_q - 16'd1);
    tp_ph_n   = '0;
    tp_left_n = tp_left;
    if (!tp_arm) begin
      tp_ph_n = tp_wrap ? '0 : tp_ph + 16'd1;
      if (tp_wrap && tp_left != '0) begin
        tp_left_n = tp_left - 16'd1;
      end
    end
    ext_n = (tp_per_q >= 16'd2) && (tp_left_n != '0) &&
            (tp_ph_n < (tp_per_q >> 1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tp_per_q   <= '0;
      tp_num_q   <= '0;
      tp_ph      <= '0;
      tp_left    <= '0;
      tp_arm     <= 1'b0;
      EXT_TPULSE <= 1'b0;
    end else begin
      if (accept) begin
        tp_per_q <= TP_PERIOD;
        tp_num_q <= TP_NUM;
      end
      if (state_n != S_OPEN) begin
        tp_arm     <= 1'b0;
        EXT_TPULSE <= 1'b0;
      end else if (state != S_OPEN) begin
        tp_arm     <= 1'b1;
        tp_ph      <= '0;
        tp_left    <= tp_num_q;
        EXT_TPULSE <= 1'b0;
      end else begin
        tp_arm     <= 1'b0;
        tp_ph      <= tp_ph_n;
        tp_left    <= tp_left_n;
        EXT_TPULSE <= ext_n;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tpx3_shutter_seq.sv
// Self-checking bench for tpx3_shutter_seq. Expected waveforms are computed
// per cycle from the frame-schedule arithmetic (open times, counts, end
// cycle) rather than from any state machine.

module tb_tpx3_shutter_seq;

  logic        CLK, RST_N, START, STOP, T0_EN;
  logic [31:0] DELAY, LENGTH, GAP;
  logic [15:0] REPEAT;
  logic        SHUTTER, T0_SYNC, BUSY, DONE;
  logic [15:0] FRAME_CNT;
`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
  logic [15:0] TP_PERIOD, TP_NUM;
  logic        EXT_TPULSE;
`endif

  int tests = 0;
  int fails = 0;

  tpx3_shutter_seq #(.CNT_WIDTH(32), .FRAME_WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .T0_EN(T0_EN),
    .DELAY(DELAY), .LENGTH(LENGTH), .GAP(GAP), .REPEAT(REPEAT),
`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
    .TP_PERIOD(TP_PERIOD), .TP_NUM(TP_NUM), .EXT_TPULSE(EXT_TPULSE),
`endif
    .SHUTTER(SHUTTER), .T0_SYNC(T0_SYNC), .BUSY(BUSY), .DONE(DONE),
    .FRAME_CNT(FRAME_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Frames completed by cycle c: frame k closes after cycle 2+d+k*p+l-1.
  function automatic int exp_cnt(input int c, input int d, input int l,
                                 input int p, input int r);
    int n;
    if (c < 2 + d + l) return 0;
    n = (c - 2 - d - l) / p + 1;
    if (r != 0 && n > r) n = r;
    return n;
  endfunction

  // Runs one sequence: START sampled at edge 0, optional STOP sampled at
  // edge stop_n (0 = none). Called and returning 1 time unit after a
  // rising edge with the sequencer idle.
  task automatic run_seq(input bit t0en, input int d, input int lr, input int gr,
                         input int r, input int stop_n, input int tpp, input int tpn);
    int l, g, p, end_c, eff, off, o;
    bit sh, ext;
    l = (lr == 0) ? 1 : lr;
    g = (gr == 0) ? 1 : gr;
    p = l + g;
    end_c = (r != 0) ? 2 + d + (r - 1) * p + l : 1000000;
    if (stop_n != 0 && stop_n + 1 < end_c) end_c = stop_n + 1;
    T0_EN = t0en; DELAY = d; LENGTH = lr; GAP = gr; REPEAT = 16'(r);
`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
    TP_PERIOD = 16'(tpp); TP_NUM = 16'(tpn);
`endif
    START = 1'b1; STOP = 1'b0;
    tick();
    START = 1'b0;
    for (int c = 1; c <= end_c + 1; c++) begin
      eff = (stop_n != 0 && c > stop_n) ? stop_n : c;
      off = (c >= 2 + d) ? (c - 2 - d) % p : -1;
      sh  = (c < end_c) && (off >= 0) && (off < l);
      o   = off - 1;
      ext = sh && o >= 0 && tpp >= 2 && o < tpn * tpp && (o % ((tpp < 1) ? 1 : tpp)) < tpp / 2;
      chk("busy", 64'(BUSY), 64'(c < end_c));
      chk("done", 64'(DONE), 64'(c == end_c));
      chk("t0_sync", 64'(T0_SYNC), 64'(c == 1 && t0en));
      chk("shutter", 64'(SHUTTER), 64'(sh));
      chk("frame_cnt", 64'(FRAME_CNT), 64'(16'(exp_cnt(eff, d, l, p, r))));
`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
      chk("ext_tpulse", 64'(EXT_TPULSE), 64'(ext));
`else
      if (ext && tpn < 0) $display("unreachable");
`endif
      if (c <= end_c) begin
        STOP  = (stop_n != 0 && c == stop_n);
        START = (c < end_c) && ($urandom_range(0, 3) == 0);
        // Config inputs must be ignored once latched
        T0_EN = $urandom_range(0, 1); DELAY = $urandom_range(0, 9);
        LENGTH = $urandom_range(0, 9); GAP = $urandom_range(0, 9);
        REPEAT = 16'($urandom_range(0, 9));
        tick();
      end
    end
    START = 1'b0; STOP = 1'b0;
  endtask

  initial begin
    int d, l, g, r, p, e, sn;
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; T0_EN = 1'b0;
    DELAY = '0; LENGTH = '0; GAP = '0; REPEAT = '0;
`ifdef TPX3_SHUTTER_SEQ_TPULSE_EN
    TP_PERIOD = '0; TP_NUM = '0;
`endif
    #1;
    chk("rst_shutter", 64'(SHUTTER), 64'(0));
    chk("rst_t0", 64'(T0_SYNC), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_cnt", 64'(FRAME_CNT), 64'(0));
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // Reference schedule: opens at 5, 12, 19; done at 24
    run_seq(1'b1, 3, 5, 2, 3, 0, 4, 3);
    // Zero lengths behave as one cycle
    run_seq(1'b0, 0, 0, 0, 2, 0, 0, 0);

    // START and STOP together while idle are ignored
    START = 1'b1; STOP = 1'b1;
    tick();
    START = 1'b0; STOP = 1'b0;
    chk("ss_busy", 64'(BUSY), 64'(0));
    chk("ss_done", 64'(DONE), 64'(0));
    chk("ss_t0", 64'(T0_SYNC), 64'(0));
    tick();
    chk("ss_busy2", 64'(BUSY), 64'(0));
    chk("ss_done2", 64'(DONE), 64'(0));

    // Continuous run stopped mid-OPEN of frame index 10
    d = $urandom_range(0, 3);
    run_seq(1'b1, d, 4, 4, 0, 2 + d + 10 * 8 + 1, 3, 2);

    // Test-pulse frames: full train, then truncated by shutter close
    run_seq(1'b0, 1, 20, 3, 1, 0, 4, 3);
    run_seq(1'b0, 0, 6, 2, 2, 0, 4, 3);

    // Asynchronous reset in the middle of an OPEN phase
    T0_EN = 1'b1; DELAY = 0; LENGTH = 20; GAP = 1; REPEAT = 16'd1;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (4) tick();
    chk("pre_rst_shutter", 64'(SHUTTER), 64'(1));
    #2 RST_N = 1'b0;
    #1;
    chk("arst_shutter", 64'(SHUTTER), 64'(0));
    chk("arst_busy", 64'(BUSY), 64'(0));
    chk("arst_done", 64'(DONE), 64'(0));
    chk("arst_cnt", 64'(FRAME_CNT), 64'(0));
    tick();
    RST_N = 1'b1;
    tick();
    run_seq(1'b1, 2, 3, 2, 2, 0, 2, 1);

    // Randomised sequences, half of them aborted
    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(0, 6);
      l = $urandom_range(0, 6);
      g = $urandom_range(0, 4);
      r = $urandom_range(1, 4);
      p = ((l == 0) ? 1 : l) + ((g == 0) ? 1 : g);
      e = 2 + d + (r - 1) * p + ((l == 0) ? 1 : l);
      sn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e - 2) : 0;
      run_seq(1'($urandom_range(0, 1)), d, l, g, r, sn,
              $urandom_range(0, 5), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute guard so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tpx3_shutter_seq.md
# tpx3_shutter_seq

Frame sequencer for the Timepix3 readout chain. On a single start pulse it drives T0_Sync and Shutter through a programmed delay / open / gap schedule for a fixed or unlimited number of frames. It replaces software toggling of the GPIO-driven Shutter and T0_Sync lines, so acquisition windows are cycle-exact relative to the data the tpx3_rx path streams into the arbiter and BRAM FIFO.

## Interface
- CNT_WIDTH, 32: width of the DELAY, LENGTH and GAP counters (cycles).
- FRAME_WIDTH, 16: width of REPEAT and FRAME_CNT.
- CLK  input  1  sequencer clock; all logic is on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  start request; sampled only in IDLE.
- STOP  input  1  abort request; honoured in any non-IDLE state.
- T0_EN  input  1  issue a T0_SYNC pulse at sequence start.
- DELAY  input  CNT_WIDTH  cycles from T0 to the first shutter open.
- LENGTH  input  CNT_WIDTH  shutter-open cycles per frame; 0 is treated as 1.
- GAP  input  CNT_WIDTH  shutter-closed cycles between frames; 0 is treated as 1.
- REPEAT  input  FRAME_WIDTH  number of frames; 0 means continuous.
- SHUTTER  output  1  shutter line (active high).
- T0_SYNC  output  1  one-cycle timestamp reset pulse.
- BUSY  output  1  high whenever the state is not IDLE.
- DONE  output  1  one-cycle pulse at the end of a sequence (normal end or abort).
- FRAME_CNT  output  FRAME_WIDTH  frames completed since the last accepted START.

## Operation
- States: IDLE, T0, WAIT, OPEN, GAP.
- Config latch: DELAY, LENGTH, GAP, REPEAT and T0_EN are captured on START acceptance. Input changes during a sequence have no effect.
- IDLE -> T0 when START=1 and STOP=0.
  - On acceptance, FRAME_CNT clears to 0.
  - If START and STOP are both high in IDLE, STOP wins: the request is ignored and DONE does not pulse.
- T0: lasts 1 cycle. T0_SYNC = latched T0_EN. Then go to WAIT if DELAY > 0, else to OPEN.
- WAIT: lasts DELAY cycles, then go to OPEN.
- OPEN: SHUTTER = 1 for max(LENGTH, 1) cycles. On exit, FRAME_CNT increments (wraps modulo 2^FRAME_WIDTH). Then:
  - last frame (REPEAT ≠ 0 and incremented count == REPEAT): go to IDLE and pulse DONE;
  - otherwise go to GAP.
- GAP: SHUTTER = 0 for max(GAP, 1) cycles, then back to OPEN. There is no gap after the last frame.
- STOP in T0, WAIT, OPEN or GAP:
  - next state is IDLE and DONE pulses;
  - SHUTTER falls on the next edge;
  - a frame aborted in OPEN is not counted.
- START while BUSY is ignored.
- Counters are down-counters loaded with (value − 1) at state entry. No arithmetic overflow is possible.

## Timing
- Reset values: SHUTTER=0, T0_SYNC=0, BUSY=0, DONE=0, FRAME_CNT=0, state=IDLE. Reset takes effect immediately (asynchronous), including mid-sequence.
- All outputs are registered.
- Cycle numbering: edge 0 is the edge that samples START in IDLE.
- Cycle 1: BUSY=1; T0_SYNC=1 if T0_EN.
- SHUTTER rises at cycle 2+DELAY and stays high max(LENGTH, 1) cycles.
- Frame k (k ≥ 0) opens at 2 + DELAY + k·(max(LENGTH, 1) + max(GAP, 1)).
- Last frame: in the cycle SHUTTER falls, FRAME_CNT=REPEAT, DONE=1 and BUSY=0 together.
- STOP sampled at edge n: SHUTTER=0, BUSY=0 and DONE=1 in cycle n+1.
- Minimum re-start: START is accepted in the first IDLE cycle after DONE.

## Configuration
- TPX3_SHUTTER_SEQ_TPULSE_EN, defined: adds the following ports.
  - TP_PERIOD (input, 16): cycles per test pulse.
  - TP_NUM (input, 16): pulses per frame; latched on START.
  - EXT_TPULSE (output, 1): test-pulse line.
  - Behaviour in each OPEN phase:
    - first pulse starts in the cycle after SHUTTER rises;
    - each pulse is high for floor(TP_PERIOD/2) cycles, then low for the rest of the period;
    - TP_NUM pulses are issued per frame;
    - EXT_TPULSE is forced to 0 when SHUTTER falls or on STOP;
    - TP_PERIOD < 2 or TP_NUM = 0 produces no pulses.
  - EXT_TPULSE resets to 0.
- TPX3_SHUTTER_SEQ_TPULSE_EN, undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset mid-OPEN, then release: all outputs 0 and state IDLE immediately; the next START runs normally from FRAME_CNT=0.
- T0_EN=1, DELAY=3, LENGTH=5, GAP=2, REPEAT=3, START at edge 0:
  - T0_SYNC=1 in cycle 1 only;
  - SHUTTER high in cycles 5–9, 12–16 and 19–23;
  - DONE=1 and FRAME_CNT=3 in cycle 24.
- DELAY=0, LENGTH=0, GAP=0, REPEAT=2: SHUTTER high in cycles 2 and 4; DONE in cycle 5.
- REPEAT=0, LENGTH=4, GAP=4, STOP after 10 frames in mid-OPEN: SHUTTER=0 the next cycle; FRAME_CNT=10; one DONE pulse; START pulses issued during the run are ignored.
- START and STOP together in IDLE: BUSY stays 0 and no DONE pulse.
- With TPX3_SHUTTER_SEQ_TPULSE_EN: TP_PERIOD=4, TP_NUM=3, LENGTH=20 gives EXT_TPULSE pulses of 2 cycles at offsets +1, +5 and +9 from the SHUTTER rise. With LENGTH=6, EXT_TPULSE is truncated to 0 when SHUTTER falls.
